// File: rtl/vproc_mem_arbiter_pkg.sv
// Purpose: shared types and defaults for the VProc memory arbiter and its round-robin picker.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: arbiter state encoding, default memory segment and error read data.
package vproc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  localparam logic [15:0] MEMSEG_DEF   = 16'h0000;
  localparam logic [31:0] ERR_DATA_DEF = 32'hdeadbeef;

endpackage

// File: rtl/vproc_mem_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker; first valid index after 'last', wrapping mod NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
// Ports: valid (per-requester request), last (previous owner index)
//        -> onehot (chosen requester), idx (its index), any (some request valid).
module vproc_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    cand   = 0;
    any    = |valid;
    // Walk from the farthest candidate to the nearest so the nearest valid
    // one after 'last' is what remains in idx.
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NREQ;
      if (valid[cand]) idx = IW'(cand);
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// Purpose: round-robin sharing of one Mem port between NREQ VProc-style bus masters.
// Latency: from request seen in IDLE, write/miss ack after 1 cycle, read ack after 2.
// Backpressure: masters hold addr/we/rd/wdata until their ack; waiting requests queue implicitly.
// Ports: clk, rst (sync, active-high); req_addr/req_we/req_rd/req_wdata per requester;
//        ack/err one-cycle pulses, rdata; mem_cs/mem_we/mem_a/mem_di/mem_do to Mem; grant (debug).
module vproc_mem_arbiter
  import vproc_arb_pkg::*;
#(
  parameter int          NREQ      = 4,
  parameter int          LOG2WORDS = 14,
  parameter logic [15:0] MEMSEG    = MEMSEG_DEF,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rdata,
  output logic [NREQ-1:0]      err,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [LOG2WORDS-1:0] mem_a,
  output logic [31:0]          mem_di,
  input  logic [31:0]          mem_do,
  output logic [NREQ-1:0]      grant
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_q;
  logic [NREQ-1:0] grant_q;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic        own_we;
  logic        hit;
  logic        done;
  logic        miss;
  logic        unused_addr;

  vproc_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid  (req_we | req_rd),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Owner inputs are read live; masters are required to hold them until ack.
  assign own_addr    = req_addr[32*owner_q +: 32];
  assign own_wdata   = req_wdata[32*owner_q +: 32];
  assign own_we      = req_we[owner_q];
  assign hit         = (own_addr[31:16] == MEMSEG);
  assign unused_addr = ^own_addr;

  assign mem_a  = own_addr[LOG2WORDS+1:2];
  assign mem_di = own_wdata;
  assign grant  = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
      // Pointing at the last requester makes requester 0 the first winner.
      last_q  <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_onehot;
            owner_q <= pick_idx;
            last_q  <= pick_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (hit && !own_we) begin
            state_q <= RDATA;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // rst gates every strobe so an access in flight is dropped without ack.
  always_comb begin
    mem_cs = 1'b0;
    mem_we = 1'b0;
    done   = 1'b0;
    miss   = 1'b0;
    rdata  = '0;
    if (!rst) begin
      case (state_q)
        ISSUE: begin
          if (hit) begin
            mem_cs = 1'b1;
            mem_we = own_we;
            done   = own_we;
          end else begin
            done = 1'b1;
            miss = 1'b1;
            if (!own_we) rdata = ERR_DATA;
          end
        end
        RDATA: begin
          done  = 1'b1;
          rdata = mem_do;
        end
        default: ;
      endcase
    end
  end

  assign ack = done ? grant_q : '0;
  assign err = miss ? grant_q : '0;

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// Purpose: directed self-checking bench for vproc_mem_arbiter with a behavioural Mem port.
// Latency: n/a.
// Backpressure: n/a.
module tb_vproc_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] req_addr;
  logic [3:0]   req_we;
  logic [3:0]   req_rd;
  logic [127:0] req_wdata;
  logic [3:0]   ack;
  logic [31:0]  rdata;
  logic [3:0]   err;
  logic         mem_cs;
  logic         mem_we;
  logic [13:0]  mem_a;
  logic [31:0]  mem_di;
  logic [31:0]  mem_do;
  logic [3:0]   grant;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vproc_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .grant     (grant)
  );

  // Mem model: unwritten words read as 32'hA5000000 | word address.
  logic [31:0] mem [int];

  function automatic logic [31:0] mem_word(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'hA5000000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[int'(mem_a)] = mem_di;
      else        mem_do <= mem_word(int'(mem_a));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
    req_we[i]              = we;
    req_rd[i]              = rd;
    req_addr[32*i +: 32]   = a;
    req_wdata[32*i +: 32]  = d;
  endtask

  task automatic clear_all();
    req_we    = '0;
    req_rd    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    clear_all();

    // Reset held with every requester active.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk("rst_ack",   32'(ack),    32'h0);
      chk("rst_grant", 32'(grant),  32'h0);
      chk("rst_cs",    32'(mem_cs), 32'h0);
    end
    tick(); rst = 1'b0; #1;
    chk("rel_idle_grant", 32'(grant), 32'h0);
    tick(); #1;
    chk("first_grant", 32'(grant), 32'h1);
    clear_all(); rst = 1'b1; #1;
    chk("rst_forces_cs", 32'(mem_cs), 32'h0);
    chk("rst_forces_ack", 32'(ack), 32'h0);
    tick(); rst = 1'b0;

    // Single write then read by requester 1.
    set_req(1, 1'b1, 1'b0, 32'h00000010, 32'h12345678); #1;
    chk("wr_idle_ack", 32'(ack), 32'h0);
    tick(); #1;
    chk("wr_ack",   32'(ack),    32'h2);
    chk("wr_cs",    32'(mem_cs), 32'h1);
    chk("wr_we",    32'(mem_we), 32'h1);
    chk("wr_a",     32'(mem_a),  32'h4);
    chk("wr_di",    mem_di,      32'h12345678);
    tick(); clear_all(); #1;
    chk("wr_ack_off", 32'(ack), 32'h0);
    tick(); set_req(1, 1'b0, 1'b1, 32'h00000010, 32'h0); #1;
    chk("rd_idle_ack", 32'(ack), 32'h0);
    tick(); #1;
    chk("rd_issue_ack", 32'(ack),    32'h0);
    chk("rd_issue_cs",  32'(mem_cs), 32'h1);
    chk("rd_issue_we",  32'(mem_we), 32'h0);
    tick(); #1;
    chk("rd_ack",   32'(ack), 32'h2);
    chk("rd_data",  rdata,    32'h12345678);
    tick(); clear_all(); #1;
    chk("rd_ack_off", 32'(ack), 32'h0);
    chk("rd_rdata_zero", rdata, 32'h0);

    // Contention: four reads, requester 0 re-requests after its ack.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 32'h400 + 32'(4*i), 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        req_rd[order[k-1]] = 1'b0;
      end
      #1;
      chk("rr_idle_ack", 32'(ack), 32'h0);
      tick();
      if (k == 1) req_rd[0] = 1'b1;
      #1;
      chk("rr_grant",     32'(grant), 32'h1 << order[k]);
      chk("rr_issue_ack", 32'(ack),   32'h0);
      tick(); #1;
      chk("rr_ack",   32'(ack), 32'h1 << order[k]);
      chk("rr_rdata", rdata,    32'hA5000100 + 32'(order[k]));
    end
    tick(); clear_all(); #1;
    chk("rr_done_ack", 32'(ack), 32'h0);

    // Out-of-segment read by requester 2.
    set_req(2, 1'b0, 1'b1, 32'ha0000000, 32'h0); #1;
    chk("miss_idle_cs", 32'(mem_cs), 32'h0);
    tick(); #1;
    chk("miss_ack",   32'(ack),    32'h4);
    chk("miss_err",   32'(err),    32'h4);
    chk("miss_rdata", rdata,       32'hdeadbeef);
    chk("miss_cs",    32'(mem_cs), 32'h0);
    tick(); clear_all(); #1;
    chk("miss_ack_off", 32'(ack),    32'h0);
    chk("miss_err_off", 32'(err),    32'h0);
    chk("miss_cs_off",  32'(mem_cs), 32'h0);

    // Reset while a read sits in RDATA.
    tick(); set_req(1, 1'b0, 1'b1, 32'h00000010, 32'h0);
    tick(); #1;
    chk("mid_grant", 32'(grant), 32'h2);
    tick(); rst = 1'b1; #1;
    chk("mid_rst_ack",   32'(ack), 32'h0);
    chk("mid_rst_rdata", rdata,    32'h0);
    tick(); rst = 1'b0; clear_all();
    set_req(0, 1'b0, 1'b1, 32'h00000010, 32'h0);
    set_req(3, 1'b0, 1'b1, 32'h00000010, 32'h0);
    #1;
    chk("post_rst_ack",   32'(ack),   32'h0);
    chk("post_rst_grant", 32'(grant), 32'h0);
    tick(); #1;
    chk("post_rst_first", 32'(grant), 32'h1);
    tick(); #1;
    chk("post_rst_ack0",  32'(ack), 32'h1);
    chk("post_rst_rdata", rdata,    32'h12345678);
    tick(); clear_all(); #1;
    chk("post_rst_off", 32'(ack), 32'h0);

    // Write and read both high on requester 3: treated as write.
    tick(); set_req(3, 1'b1, 1'b1, 32'h00000020, 32'hcafef00d); #1;
    tick(); #1;
    chk("wrd_ack", 32'(ack),    32'h8);
    chk("wrd_cs",  32'(mem_cs), 32'h1);
    chk("wrd_we",  32'(mem_we), 32'h1);
    chk("wrd_a",   32'(mem_a),  32'h8);
    tick(); clear_all(); #1;
    chk("wrd_ack_off", 32'(ack), 32'h0);
    chk("wrd_mem",     mem_word(8), 32'hcafef00d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
